// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates the ALU and load-unit writebacks onto the single register-file
// write port and keeps a busy scoreboard. Latency: 1 cycle from accept to rf_we_o.
// Backpressure: ready is combinational, one grant per cycle, none while flush_i is high.
// Build option WB_ARB_FIXED_PRIO_EN: loads always win contention and last_grant is absent.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [AW-1:0]    alu_rd_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic             mem_valid_i,
    output logic             mem_ready_o,
    input  logic [AW-1:0]    mem_rd_i,
    input  logic [XLEN-1:0]  mem_data_i,
    output logic             rf_we_o,
    output logic [AW-1:0]    rf_waddr_o,
    output logic [XLEN-1:0]  rf_wdata_o,
    output logic [NREGS-1:0] busy_o
);

    logic             alu_grant;
    logic             mem_grant;
    logic [AW-1:0]    sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic             we_q;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

`ifndef WB_ARB_FIXED_PRIO_EN
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e last_grant;
`endif

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (rst_ni && !flush_i) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            mem_grant = mem_valid_i;
            alu_grant = alu_valid_i && !mem_valid_i;
`else
            if (alu_valid_i && mem_valid_i) begin
                alu_grant = (last_grant == SRC_MEM);
                mem_grant = (last_grant == SRC_ALU);
            end else begin
                alu_grant = alu_valid_i;
                mem_grant = mem_valid_i;
            end
`endif
        end
    end

    assign alu_ready_o = alu_grant;
    assign mem_ready_o = mem_grant;
    assign sel_rd      = mem_grant ? mem_rd_i   : alu_rd_i;
    assign sel_data    = mem_grant ? mem_data_i : alu_data_i;

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= SRC_MEM;
        end else if (alu_grant) begin
            last_grant <= SRC_ALU;
        end else if (mem_grant) begin
            last_grant <= SRC_MEM;
        end
    end
`endif

    // x0 writes still capture address/data but never raise the write enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q       <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (alu_grant || mem_grant) begin
            we_q       <= (sel_rd != '0);
            rf_waddr_o <= sel_rd;
            rf_wdata_o <= sel_data;
        end else begin
            we_q       <= 1'b0;
        end
    end

    // A write sitting on the port when a flush arrives is dropped before the register file
    assign rf_we_o = we_q && !flush_i;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (rf_we_o) begin
                busy_d[rf_waddr_o] = 1'b0;
            end
            if (issue_valid_i && (issue_rd_i != '0)) begin
                busy_d[issue_rd_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural model
// of the writeback port and scoreboard.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [AW-1:0]    mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic [NREGS-1:0] busy;

    int checks = 0;
    int errors = 0;

    // Model state: pending write on the port, scoreboard, and who won last contention
    bit               m_we;
    logic [AW-1:0]    m_addr;
    logic [XLEN-1:0]  m_data;
    logic [NREGS-1:0] m_busy;
    bit               m_last_mem;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void pred_grant(output bit ga, output bit gm);
        ga = 0;
        gm = 0;
        if (rst_n && !flush) begin
            if (alu_valid && mem_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
                gm = 1;
`else
                if (m_last_mem) ga = 1; else gm = 1;
`endif
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
    endfunction

    function automatic bit exp_we();
        return m_we && !flush;
    endfunction

    task automatic idle_inputs();
        flush = 0; issue_valid = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    // Advance one clock; the model computes what the port and scoreboard become.
    task automatic tick();
        bit ga, gm;
        logic [NREGS-1:0] nb;
        pred_grant(ga, gm);
        nb = m_busy;
        if (flush) nb = '0;
        else begin
            if (exp_we()) nb[m_addr] = 1'b0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
        end
        @(posedge clk);
        m_busy = nb;
        if (ga) begin
            m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data; m_last_mem = 0;
        end else if (gm) begin
            m_we = (mem_rd != 0); m_addr = mem_rd; m_data = mem_data; m_last_mem = 1;
        end else begin
            m_we = 0;
        end
        #2;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_last_mem = 1;
        #13;
        rst_n = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rf_we !== 1'b0 || busy !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            errors++;
            $display("FAIL reset_idle: we=%b busy=%h addr=%0d data=%h, want all 0", rf_we, busy, rf_waddr, rf_wdata);
        end
        issue_valid = 1; issue_rd = 6;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h1234_5678;
        tick();
        idle_inputs();
        alu_valid = 1; alu_rd = 8; alu_data = 32'h0BAD_F00D;
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || busy !== '0 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: we=%b addr=%0d data=%h busy=%h rdy=%b, want all 0",
                     rf_we, rf_waddr, rf_wdata, busy, alu_ready);
        end
        do_reset();
        checks++;
        if (rf_we !== 1'b0 || busy !== '0) begin
            errors++;
            $display("FAIL reset_release: we=%b busy=%h, want 0/0", rf_we, busy);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: alu_rdy=%b mem_rdy=%b, want 1/0", alu_ready, mem_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%h, want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL single_oneshot: we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_seq [4];
        int ai, mi;
`ifdef WB_ARB_FIXED_PRIO_EN
        exp_seq = '{5'd11, 5'd12, 5'd13, 5'd14};
`else
        exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12};
`endif
        do_reset();
        ai = 1; mi = 11;
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1; alu_rd = AW'(ai); alu_data = 32'hA000_0000 + ai;
            mem_valid = 1; mem_rd = AW'(mi); mem_data = 32'hB000_0000 + mi;
            #1;
            checks++;
            if ((alu_ready && mem_ready) !== 1'b0) begin
                errors++;
                $display("FAIL contention_onehot: alu_rdy=%b mem_rdy=%b", alu_ready, mem_ready);
            end
            if (alu_ready) ai++;
            if (mem_ready) mi++;
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== exp_seq[c]) begin
                errors++;
                $display("FAIL contention_grant%0d: we=%b addr=%0d, want 1/%0d", c, rf_we, rf_waddr, exp_seq[c]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        mem_valid = 1; mem_rd = 0; mem_data = 7;
        #1;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: mem_rdy=%b, want 1", mem_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rf_we !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: we=%b busy0=%b, want 0/0", rf_we, busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        checks++;
        if (busy[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set: busy9=%b, want 1", busy[9]);
        end
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        tick();
        alu_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || busy[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_pending: we=%b busy9=%b, want 1/1", rf_we, busy[9]);
        end
        tick();
        checks++;
        if (busy[9] !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: busy9=%b, want 0", busy[9]);
        end
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9A;
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        checks++;
        if (busy[9] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: busy9=%b, want 1", busy[9]);
        end
    endtask

    task automatic test_flush();
        logic [AW-1:0] regs [7];
        regs = '{5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            issue_valid = 1; issue_rd = regs[i];
            tick();
        end
        issue_valid = 0;
        alu_valid = 1; alu_rd = 20; alu_data = 32'h2020;
        tick();
        alu_rd = 21; alu_data = 32'h2121;
        checks++;
        if (busy !== 32'h0000_0F0E || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: busy=%h we=%b, want 00000f0e/1", busy, rf_we);
        end
        flush = 1; mem_valid = 1; mem_rd = 22; issue_valid = 1; issue_rd = 12;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: alu_rdy=%b mem_rdy=%b we=%b, want 0/0/0", alu_ready, mem_ready, rf_we);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy !== '0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: busy=%h we=%b, want 0/0", busy, rf_we);
        end
    endtask

    task automatic test_random();
        bit ga, gm;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 15) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_rd = AW'($urandom);
            if (!alu_valid) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd = AW'($urandom); alu_data = $urandom;
            end
            if (!mem_valid) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd = AW'($urandom); mem_data = $urandom;
            end
            #1;
            pred_grant(ga, gm);
            checks++;
            if (alu_ready !== ga || mem_ready !== gm || rf_we !== exp_we()) begin
                errors++;
                $display("FAIL rand_comb c=%0d: alu_rdy=%b mem_rdy=%b we=%b, want %b/%b/%b",
                         c, alu_ready, mem_ready, rf_we, ga, gm, exp_we());
            end
            tick();
            checks++;
            if (busy !== m_busy || rf_we !== exp_we() || (m_we && (rf_waddr !== m_addr || rf_wdata !== m_data))) begin
                errors++;
                $display("FAIL rand_state c=%0d: busy=%h we=%b addr=%0d data=%h, want %h/%b/%0d/%h",
                         c, busy, rf_we, rf_waddr, rf_wdata, m_busy, exp_we(), m_addr, m_data);
            end
            if (ga) alu_valid = 0;
            if (gm) mem_valid = 0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_source();
        test_contention();
        test_x0();
        test_scoreboard();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
